// File: rtl/arb_mux_pkg.sv
// Shared defaults and helpers for the arbitrating multiplexer (arb_mux_n, rr_pick).
package arb_mux_pkg;

  localparam int ARB_N_CH_DEF       = 4;
  localparam int ARB_DATA_WIDTH_DEF = 32;

  // Index width for n channels; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-mask priority picker: first request at or above ptr wins, else lowest request overall.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter  int N_CH  = ARB_N_CH_DEF,
  localparam int SEL_W = sel_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [N_CH-1:0]  upper;
  logic             hit_up;
  logic             hit_any;
  logic [SEL_W-1:0] idx_up;
  logic [SEL_W-1:0] idx_any;

  always_comb begin
    upper   = '0;
    idx_up  = '0;
    idx_any = '0;
    gnt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    hit_up  = |upper;
    hit_any = |req;
    // Descending scan leaves the lowest set index in each candidate.
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (upper[i]) idx_up = SEL_W'(i);
      if (req[i]) idx_any = SEL_W'(i);
    end
    gnt_idx = hit_up ? idx_up : idx_any;
    if (hit_any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-input arbitrating mux with a single registered output slot and synchronous flush.
// ARB_MUX_RR_EN defined: round-robin pointer; undefined: fixed priority (lowest index wins).
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter  int N_CH       = ARB_N_CH_DEF,
  parameter  int DATA_WIDTH = ARB_DATA_WIDTH_DEF,
  localparam int SEL_W      = sel_width(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_CH-1:0]            in_valid,
  input  logic [N_CH*DATA_WIDTH-1:0] in_data,
  output logic [N_CH-1:0]            in_ready,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]           out_sel,
  input  logic                       out_ready
);

  logic [SEL_W-1:0]      ptr_p0;
  logic [SEL_W-1:0]      win_idx;
  logic [N_CH-1:0]       win_gnt;
  logic                  can_load;
  logic                  grant_en;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] ch_data [N_CH];

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [SEL_W-1:0]      sel_p1;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    assign ch_data[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (in_valid),
    .ptr     (ptr_p0),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  assign can_load = !vld_p1 || out_ready;
  assign grant_en = !rst && !flush && can_load;
  assign in_ready = grant_en ? win_gnt : '0;
  assign xfer     = grant_en && (|in_valid);

`ifdef ARB_MUX_RR_EN
  logic [SEL_W-1:0] ptr_nxt;

  assign ptr_nxt = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + SEL_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= '0;
    end else if (xfer) begin
      ptr_p0 <= ptr_nxt;
    end
  end
`else
  assign ptr_p0 = '0;
`endif

  // Stage p1: the single output slot, loaded from the granted channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
    end else if (flush) begin
      vld_p1 <= 1'b0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= ch_data[win_idx];
      sel_p1  <= win_idx;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n (N_CH=4, DATA_WIDTH=32): directed vectors with literal expectations plus a behavioural model.
module tb_arb_mux_n;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;
`ifdef ARB_MUX_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  arb_mux_n #(.N_CH(N), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Literal expectations posted by the stimulus for the current cycle.
  logic          lit_rdy_en, lit_out_en;
  logic [N-1:0]  lit_rdy;
  logic          lit_vld;
  logic [DW-1:0] lit_data;
  logic [SW-1:0] lit_sel;

  // Model state: what the output slot and pointer must hold.
  bit            m_known = 1'b0;
  bit            m_vld;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            m_ptr;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Winner under the arbitration rules, or -1 when no grant is allowed.
  function automatic int model_winner();
    if (rst || flush || (m_vld && !out_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [N-1:0] eg;
    w  = model_winner();
    eg = (w >= 0) ? N'(1 << w) : '0;
    chk("in_ready", 32'(in_ready), 32'(eg));
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_vld));
      chk("out_data", out_data, m_data);
      chk("out_sel", 32'(out_sel), 32'(m_sel));
    end
    if (lit_rdy_en) chk("lit_in_ready", 32'(in_ready), 32'(lit_rdy));
    if (lit_out_en) begin
      chk("lit_out_valid", 32'(out_valid), 32'(lit_vld));
      chk("lit_out_data", out_data, lit_data);
      chk("lit_out_sel", 32'(out_sel), 32'(lit_sel));
    end
    if (rst) begin
      m_known = 1'b1;
      m_vld   = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = 0;
    end else if (flush) begin
      m_vld = 1'b0;
    end else if (w >= 0) begin
      m_vld  = 1'b1;
      m_data = in_data[w*DW +: DW];
      m_sel  = w;
      if (RR) m_ptr = (w + 1) % N;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
  end

  task automatic drive(input logic r, input logic f, input logic [N-1:0] v, input logic o,
                       input logic [23:0] t);
    rst       = r;
    flush     = f;
    in_valid  = v;
    out_ready = o;
    for (int k = 0; k < N; k++) in_data[k*DW +: DW] = {t, 8'(k)};
    lit_rdy_en = 1'b0;
    lit_out_en = 1'b0;
  endtask

  task automatic exp_rdy(input logic [N-1:0] r);
    lit_rdy_en = 1'b1;
    lit_rdy    = r;
  endtask

  task automatic exp_out(input logic v, input logic [DW-1:0] d, input logic [SW-1:0] s);
    lit_out_en = 1'b1;
    lit_vld    = v;
    lit_data   = d;
    lit_sel    = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_seq [6] = '{0, 1, 2, 3, 0, 1};
    drive(1'b1, 1'b0, 4'b0000, 1'b1, 24'h0);
    tick();

    // Reset held two cycles with every channel requesting.
    drive(1'b1, 1'b0, 4'b1111, 1'b1, 24'h111111); exp_rdy(4'b0000); tick();
    drive(1'b1, 1'b0, 4'b1111, 1'b1, 24'h111111); exp_rdy(4'b0000); tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 24'h0);      exp_rdy(4'b0000); exp_out(1'b0, 32'h0, 2'd0); tick();

    // Single source on channel 2.
    drive(1'b0, 1'b0, 4'b0100, 1'b1, 24'h0);
    in_data[2*DW +: DW] = 32'hDEADBEEF;
    exp_rdy(4'b0100); tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 24'h0); exp_rdy(4'b0000); exp_out(1'b1, 32'hDEADBEEF, 2'd2); tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 24'h0); exp_out(1'b0, 32'hDEADBEEF, 2'd2); tick();
    drive(1'b1, 1'b0, 4'b0000, 1'b1, 24'h0); tick();

    // Fairness with all channels valid and the consumer always ready.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 4'b1111, 1'b1, 24'hF00000 + 24'(i));
      exp_rdy(RR ? 4'(1 << (i % 4)) : 4'b0001);
      if (i > 0) begin
        int s;
        s = RR ? rr_seq[i-1] : 0;
        exp_out(1'b1, {24'hF00000 + 24'(i - 1), 8'(s)}, 2'(s));
      end
      tick();
    end

    // Backpressure: the held word must not move while the consumer stalls.
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 1'b0, 4'b1111, 1'b0, 24'hBBBBBB);
      exp_rdy(4'b0000);
      exp_out(1'b1, RR ? 32'hF0000501 : 32'hF0000500, RR ? 2'd1 : 2'd0);
      tick();
    end
    drive(1'b0, 1'b0, 4'b1111, 1'b1, 24'hBBBBBB);
    exp_rdy(RR ? 4'b0100 : 4'b0001);
    exp_out(1'b1, RR ? 32'hF0000501 : 32'hF0000500, RR ? 2'd1 : 2'd0);
    tick();

    // Flush while the consumer is also ready: the word is dropped.
    drive(1'b0, 1'b1, 4'b0010, 1'b1, 24'hCCCCCC);
    exp_rdy(4'b0000);
    exp_out(1'b1, RR ? 32'hBBBBBB02 : 32'hBBBBBB00, RR ? 2'd2 : 2'd0);
    tick();
    drive(1'b0, 1'b0, 4'b0010, 1'b1, 24'hCCCCCC);
    exp_rdy(4'b0010);
    exp_out(1'b0, RR ? 32'hBBBBBB02 : 32'hBBBBBB00, RR ? 2'd2 : 2'd0);
    tick();
    drive(1'b0, 1'b1, 4'b1111, 1'b1, 24'hDDDDDD); exp_rdy(4'b0000); tick();
    drive(1'b0, 1'b0, 4'b1111, 1'b1, 24'hDDDDDD);
    exp_rdy(RR ? 4'b0100 : 4'b0001);
    exp_out(1'b0, 32'hCCCCCC01, 2'd1);
    tick();

    // Reset in the middle of a stream returns the pointer home.
    drive(1'b1, 1'b0, 4'b1111, 1'b1, 24'hEEEEEE);
    exp_rdy(4'b0000);
    exp_out(1'b1, RR ? 32'hDDDDDD02 : 32'hDDDDDD00, RR ? 2'd2 : 2'd0);
    tick();
    drive(1'b0, 1'b0, 4'b1111, 1'b1, 24'hEEEEEE); exp_rdy(4'b0001); exp_out(1'b0, 32'h0, 2'd0); tick();
    drive(1'b0, 1'b0, 4'b0000, 1'b1, 24'h0);      exp_out(1'b1, 32'hEEEEEE00, 2'd0); tick();

    // Mixed traffic checked against the model only.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), 24'($urandom));
      tick();
    end

    drive(1'b0, 1'b0, 4'b0000, 1'b1, 24'h0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input registered arbitrating multiplexer, successor to the plain 2:1 select mux. It accepts up to N_CH valid/ready source channels, picks one per cycle (round-robin or fixed priority), and presents the chosen word through a single-entry output register with valid/ready handshake and synchronous flush. It is used wherever several pipeline producers share one consumer: fetch/LSU memory port sharing, writeback source selection, and debug/CSR access merging.

## Interface
- N_CH, default 4: number of input channels, 1..16.
- DATA_WIDTH, default 32: payload width per channel.
- SEL_W, derived, not overridable: $clog2(N_CH) when N_CH>1, else 1.

- clk  in  1  rising-edge clock; the block has one clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous drop of the held output word.
- in_valid  in  N_CH  per-channel request.
- in_data  in  N_CH*DATA_WIDTH  flat bus; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  N_CH  one-hot-or-zero grant; channel k transfers when in_valid[k] && in_ready[k].
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_WIDTH  held word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts the word.

## Operation
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, out_sel=0, priority pointer=0. in_ready is forced to 0 combinationally while rst=1. rst overrides flush and every transfer.
- can_load = !out_valid || out_ready. Grant is issued only when can_load && !flush && |in_valid.
- Grant selection: the first valid channel found scanning upward from the pointer, with wrap modulo N_CH. in_ready has exactly one bit set, at the winner. in_ready depends combinationally on in_valid, out_valid, out_ready, flush and rst. in_ready never depends on in_data.
- On a transfer, the next edge loads out_data=in_data[winner], out_sel=winner and out_valid=1. The pointer moves to (winner+1) mod N_CH.
- If out_valid && out_ready and there is no grant, out_valid clears. out_data and out_sel keep their old values.
- If out_valid && !out_ready, out_data and out_sel are held stable and in_ready is all zero.
- flush=1: the next edge clears out_valid, no grant is issued that cycle, and the pointer is unchanged. flush combined with out_ready in the same cycle still drops the word; the consumer must ignore that handshake.
- Sources may deassert in_valid without a handshake. The arbiter does not lock a choice across cycles.
- N_CH=1: the pointer is constant 0 and out_sel is always 0.

## Timing
- Latency: 1 cycle from the in_valid/in_ready handshake to out_valid.
- Throughput: 1 word per cycle with out_ready held high. No bubble appears when draining and loading in the same cycle.
- No combinational path runs from in_data to any output. out_data and out_sel are register outputs only.

## Configuration
- ARB_MUX_RR_EN defined: round-robin operation as described above.
- ARB_MUX_RR_EN undefined: fixed priority, where the lowest-index valid channel wins. The pointer register is removed, so grant logic behaves as if the pointer were permanently 0. All other behaviour is identical.

## Structure
- Package arb_mux_pkg holds the default N_CH and DATA_WIDTH localparams and a sel_width(n) function returning the SEL_W rule.
- Sub-module rr_pick is the natural split. It implements the rotating-mask priority picker: inputs req[N_CH] and ptr[SEL_W]; outputs gnt one-hot and gnt_idx. arb_mux_n owns the output register, the pointer and the flush/handshake logic.

## Test plan
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 and out_ready=1 -> in_ready=0 throughout, then out_valid=0, out_data=0, out_sel=0.
- Single source: N_CH=4; in_valid=4'b0100, channel 2 data 0xDEADBEEF, out_ready=1 -> in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=0xDEADBEEF, out_sel=2.
- Fairness: all 4 channels valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles with ARB_MUX_RR_EN; 0,0,0,... without it.
- Backpressure: out_valid=1, out_sel=1, out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data stable and in_ready=0 for all 3 cycles. Raise out_ready -> in_ready=4'b0100 that cycle and out_sel=2 next.
- Flush: out_valid=1 with in_valid=4'b0010 and flush=1 -> in_ready=0 that cycle, out_valid=0 next cycle. The following cycle in_ready=4'b0010, because the pointer is unchanged.
- Reset mid-stream: assert rst while out_valid=1 and all channels are valid -> next cycle out_valid=0 and pointer=0. After release, the first grant goes to channel 0.
